// File: rtl/wrd_pkg.sv
// Shared constants for the weight configuration loader:
// FSM state codes, per-memory word/load sizes, strobe bit indices.
package wrd_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ASSEMBLE = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Strobe bit indices; also used as the memory select code
    localparam int unsigned EN_C1 = 0;
    localparam int unsigned EN_C2 = 1;
    localparam int unsigned EN_FC = 2;

    // Bytes per word and bytes per full load for each memory
    localparam int unsigned WORD_BYTES_C1 = 13;
    localparam int unsigned WORD_BYTES_C2 = 8;
    localparam int unsigned WORD_BYTES_FC = 4;
    localparam int unsigned LOAD_BYTES_C1 = 520;
    localparam int unsigned LOAD_BYTES_C2 = 640;
    localparam int unsigned LOAD_BYTES_FC = 3328;
    localparam int unsigned LOAD_BYTES   = 4488;

    // Index of the final byte of a word for memory m
    function automatic logic [3:0] word_last(input logic [1:0] m);
        unique case (m)
            2'(EN_C1): word_last = 4'(WORD_BYTES_C1 - 1);
            2'(EN_C2): word_last = 4'(WORD_BYTES_C2 - 1);
            default:   word_last = 4'(WORD_BYTES_FC - 1);
        endcase
    endfunction

    function automatic logic [2:0] mem_onehot(input logic [1:0] m);
        mem_onehot = 3'b001 << m;
    endfunction

endpackage

// File: rtl/wrd_cfg_addr_gen.sv
// Target counter: addr fastest, then bank, then memory (conv1, conv2, fc).
// Ports: clr_i restarts at conv1/0/0, adv_i steps; outputs mem/bank/addr, last flags.
module wrd_cfg_addr_gen
    import wrd_pkg::*;
#(
    parameter int C1_BANKS = 5,
    parameter int C1_ADDRS = 8,
    parameter int C2_BANKS = 5,
    parameter int C2_ADDRS = 16,
    parameter int FC_BANKS = 4,
    parameter int FC_ADDRS = 208
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] mem_o,
    output logic [2:0] bank_o,
    output logic [7:0] addr_o,
    output logic       last_mem_o,
    output logic       last_all_o
);

    logic [1:0] mem_q;
    logic [2:0] bank_q;
    logic [7:0] addr_q;
    logic [2:0] bank_max;
    logic [7:0] addr_max;

    always_comb begin
        unique case (mem_q)
            2'(EN_C1): begin
                bank_max = 3'(C1_BANKS - 1);
                addr_max = 8'(C1_ADDRS - 1);
            end
            2'(EN_C2): begin
                bank_max = 3'(C2_BANKS - 1);
                addr_max = 8'(C2_ADDRS - 1);
            end
            default: begin
                bank_max = 3'(FC_BANKS - 1);
                addr_max = 8'(FC_ADDRS - 1);
            end
        endcase
    end

    assign last_mem_o = (addr_q == addr_max) && (bank_q == bank_max);
    assign last_all_o = last_mem_o && (mem_q == 2'(EN_FC));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q  <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else if (clr_i) begin
            mem_q  <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else if (adv_i) begin
            if (addr_q == addr_max) begin
                addr_q <= '0;
                if (bank_q == bank_max) begin
                    bank_q <= '0;
                    if (mem_q != 2'(EN_FC)) mem_q <= mem_q + 2'd1;
                end else begin
                    bank_q <= bank_q + 3'd1;
                end
            end else begin
                addr_q <= addr_q + 8'd1;
            end
        end
    end

    assign mem_o  = mem_q;
    assign bank_o = bank_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/wrd_cfg_loader.sv
// Loads conv1/conv2/fc weight memories from a byte stream, one word per write.
// Ports: start_i, cfg byte stream, wr/rd strobes, bank/addr/data, busy/done/err.
// Optional readback check of every write: define WRD_CFG_READBACK_EN.
module wrd_cfg_loader
    import wrd_pkg::*;
#(
    parameter int C1_BANKS = 5,
    parameter int C1_ADDRS = 8,
    parameter int C2_BANKS = 5,
    parameter int C2_ADDRS = 16,
    parameter int FC_BANKS = 4,
    parameter int FC_ADDRS = 208
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [7:0]   cfg_data_i,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    output logic [2:0]   wr_en_o,
    output logic [2:0]   rd_en_o,
    output logic [2:0]   bank_o,
    output logic [7:0]   addr_o,
    output logic [103:0] wr_data_o,
    input  logic [103:0] conv1_rd_data_i,
    input  logic [63:0]  conv2_rd_data_i,
    input  logic [31:0]  fc_rd_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [103:0] word_q, word_d;
    logic [1:0]   mem;
    logic         clr, adv, fin;
    logic         last_mem, last_all;

    wrd_cfg_addr_gen #(
        .C1_BANKS(C1_BANKS), .C1_ADDRS(C1_ADDRS),
        .C2_BANKS(C2_BANKS), .C2_ADDRS(C2_ADDRS),
        .FC_BANKS(FC_BANKS), .FC_ADDRS(FC_ADDRS)
    ) u_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr),
        .adv_i      (adv),
        .mem_o      (mem),
        .bank_o     (bank_o),
        .addr_o     (addr_o),
        .last_mem_o (last_mem),
        .last_all_o (last_all)
    );

`ifdef WRD_CFG_READBACK_EN
    // chk_q: 0 = read issued this cycle, 1 = read data present this cycle
    logic         chk_q, chk_d;
    logic         err_q, err_d;
    logic [103:0] rd_sel;
    logic         mis;

    always_comb begin
        unique case (mem)
            2'(EN_C1): rd_sel = conv1_rd_data_i;
            2'(EN_C2): rd_sel = {40'd0, conv2_rd_data_i};
            default:   rd_sel = {72'd0, fc_rd_data_i};
        endcase
    end

    // word_q is zero above the word width, so a full compare is width-masked
    assign mis = (rd_sel != word_q);
`else
    logic unused_rd;
    assign unused_rd = ^{conv1_rd_data_i, conv2_rd_data_i, fc_rd_data_i,
                         last_mem};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        clr     = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
`ifdef WRD_CFG_READBACK_EN
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_ASSEMBLE;
                    cnt_d   = '0;
                    word_d  = '0;
                    clr     = 1'b1;
`ifdef WRD_CFG_READBACK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_ASSEMBLE: begin
                if (cfg_valid_i) begin
                    word_d[{cnt_q, 3'b000} +: 8] = cfg_data_i;
                    if (cnt_q == word_last(mem)) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_WRITE: begin
`ifdef WRD_CFG_READBACK_EN
                state_d = ST_CHECK;
                chk_d   = 1'b0;
`else
                fin = 1'b1;
`endif
            end
`ifdef WRD_CFG_READBACK_EN
            ST_CHECK: begin
                if (!chk_q) begin
                    chk_d = 1'b1;
                end else begin
                    chk_d = 1'b0;
                    if (mis) err_d = 1'b1;
                    fin = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // word finished: clear assembly, then next target or done
        if (fin) begin
            word_d = '0;
            if (last_all) begin
                state_d = ST_DONE;
            end else begin
                adv     = 1'b1;
                state_d = ST_ASSEMBLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef WRD_CFG_READBACK_EN
            chk_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef WRD_CFG_READBACK_EN
            chk_q   <= chk_d;
            err_q   <= err_d;
`endif
        end
    end

    assign cfg_ready_o = (state_q == ST_ASSEMBLE);
    assign wr_en_o     = (state_q == ST_WRITE) ? mem_onehot(mem) : 3'b000;
    assign wr_data_o   = word_q;
    assign busy_o      = (state_q == ST_ASSEMBLE) || (state_q == ST_WRITE) ||
                         (state_q == ST_CHECK);
    assign done_o      = (state_q == ST_DONE);

`ifdef WRD_CFG_READBACK_EN
    assign rd_en_o = (state_q == ST_CHECK && !chk_q) ? mem_onehot(mem) : 3'b000;
    // mismatch is flagged in the same cycle the read data arrives
    assign err_o   = err_q || (state_q == ST_CHECK && chk_q && mis);
`else
    assign rd_en_o = 3'b000;
    assign err_o   = 1'b0;
`endif

endmodule
